// File: rtl/status_scan_scheduler_pkg.sv
// Shared types and constants for the multiplexed status display scanner.
// Status codes, alarm value and width helper.
package status_scan_scheduler_pkg;

  localparam int ST_W = 2;
  localparam logic [ST_W-1:0] ST_ALARM = 2'b11;

  typedef enum logic {
    M_SCAN = 1'b0,
    M_INIT = 1'b1
  } mode_t;

  function automatic int clog2_min1(input int v);
    return (v <= 1) ? 1 : $clog2(v);
  endfunction

endpackage

// File: rtl/status_scan_scheduler_tick_gen.sv
// Digit-slot prescaler: counts clk cycles per slot while enabled.
// tick marks the last cycle of a slot.
module scan_tick_gen
  import status_scan_scheduler_pkg::*;
#(
  parameter int SCAN_DIV = 50000,
  localparam int PW = clog2_min1(SCAN_DIV)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  output logic          tick,
  output logic [PW-1:0] pcnt
);

  logic [PW-1:0] pcnt_q;
  logic [PW-1:0] pcnt_d;

  assign tick = en & (pcnt_q == PW'(SCAN_DIV - 1));
  assign pcnt = pcnt_q;

  always_comb begin
    pcnt_d = pcnt_q;
    if (tick) begin
      pcnt_d = '0;
    end else if (en) begin
      pcnt_d = pcnt_q + PW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pcnt_q <= '0;
    end else begin
      pcnt_q <= pcnt_d;
    end
  end

endmodule

// File: rtl/status_scan_scheduler.sv
// Scans N_CH snapshotted status codes onto one shared decoder,
// with anti-ghost blanking, alarm blink and sticky change flags.
module status_scan_scheduler
  import status_scan_scheduler_pkg::*;
#(
  parameter int N_CH         = 4,
  parameter int SCAN_DIV     = 50000,
  parameter int BLANK        = 2,
  parameter int BLINK_FRAMES = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [ST_W*N_CH-1:0] std_in,
  input  logic                 en,
  input  logic                 ack,
  output logic [ST_W-1:0]      std_sel,
  output logic [N_CH-1:0]      dig_en_n,
  output logic                 frame_start,
  output logic [N_CH-1:0]      chg
);

  localparam int IW = clog2_min1(N_CH);
  localparam int PW = clog2_min1(SCAN_DIV);
  localparam int BW = clog2_min1(BLINK_FRAMES);

  logic          tick;
  logic [PW-1:0] pcnt;

  logic [N_CH-1:0][ST_W-1:0] std_v;
  logic [N_CH-1:0][ST_W-1:0] snap_q, snap_d;
  logic [IW-1:0]             idx_q, idx_d;
  logic [BW-1:0]             bcnt_q, bcnt_d;
  logic                      blink_ph_q, blink_ph_d;
  mode_t                     mode_q, mode_d;
  logic [N_CH-1:0]           chg_q, chg_d;
  logic [ST_W-1:0]           std_sel_q, std_sel_d;
  logic [N_CH-1:0]           dig_en_n_q, dig_en_n_d;
  logic                      frame_start_q, frame_start_d;

  logic            last;
  logic            snap_ev;
  logic            init_ev;
  logic            blank;
  logic [ST_W-1:0] cur;
  logic [N_CH-1:0] diff;

  scan_tick_gen #(
    .SCAN_DIV(SCAN_DIV)
  ) u_tick (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (en),
    .tick (tick),
    .pcnt (pcnt)
  );

  assign std_v   = std_in;
  assign last    = (idx_q == IW'(N_CH - 1));
  assign snap_ev = tick & last;
  assign init_ev = en & (mode_q == M_INIT);
  assign cur     = snap_q[idx_q];

  always_comb begin
    for (int i = 0; i < N_CH; i++) begin
      diff[i] = (std_v[i] != snap_q[i]);
    end
  end

  always_comb begin
    idx_d      = idx_q;
    snap_d     = snap_q;
    bcnt_d     = bcnt_q;
    blink_ph_d = blink_ph_q;
    mode_d     = mode_q;
    chg_d      = ack ? '0 : chg_q;
    if (tick) begin
      idx_d = last ? '0 : idx_q + IW'(1);
    end
    if (init_ev) begin
      snap_d = std_v;
      mode_d = M_SCAN;
    end
    if (snap_ev) begin
      snap_d = std_v;
      chg_d  = chg_d | diff;
      if (bcnt_q == BW'(BLINK_FRAMES - 1)) begin
        bcnt_d     = '0;
        blink_ph_d = ~blink_ph_q;
      end else begin
        bcnt_d = bcnt_q + BW'(1);
      end
    end
  end

  // Blank at each slot start so the previous digit's code never ghosts.
  always_comb begin
    blank         = !en | (pcnt < PW'(BLANK)) | ((cur == ST_ALARM) & blink_ph_q);
    std_sel_d     = en ? cur : std_sel_q;
    dig_en_n_d    = blank ? '1 : ~(N_CH'(1) << idx_q);
    frame_start_d = snap_ev | init_ev;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q         <= '0;
      snap_q        <= '0;
      bcnt_q        <= '0;
      blink_ph_q    <= 1'b0;
      mode_q        <= M_INIT;
      chg_q         <= '0;
      std_sel_q     <= '0;
      dig_en_n_q    <= '1;
      frame_start_q <= 1'b0;
    end else begin
      idx_q         <= idx_d;
      snap_q        <= snap_d;
      bcnt_q        <= bcnt_d;
      blink_ph_q    <= blink_ph_d;
      mode_q        <= mode_d;
      chg_q         <= chg_d;
      std_sel_q     <= std_sel_d;
      dig_en_n_q    <= dig_en_n_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign std_sel     = std_sel_q;
  assign dig_en_n    = dig_en_n_q;
  assign frame_start = frame_start_q;
  assign chg         = chg_q;

endmodule
